// File: rtl/reg_status_table.sv
// Register status table: tracks, per architectural register, whether the
// newest value is in flight (PEND), already produced into the ROB (INROB),
// or up to date in the regfile (FREE), together with its producing ROB tag.

// One status entry: 2-bit state plus producing tag.
module reg_status_table_entry #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             dis_hit_i,
    input  logic [TAG_W-1:0] dis_tag_i,
    input  logic             cmt_hit_i,
    input  logic [TAG_W-1:0] cmt_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_token_i,
    output logic [1:0]       state_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam logic [1:0] ST_FREE  = 2'b00;
    localparam logic [1:0] ST_PEND  = 2'b01;
    localparam logic [1:0] ST_INROB = 2'b10;
    localparam logic [1:0] ST_ILL   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Next-state: flush > dispatch > commit (tag must match) > CDB wakeup.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        if (state_q == ST_ILL) state_d = ST_FREE;
        if (flush_i) begin
            state_d = ST_FREE;
            tag_d   = '0;
        end else if (dis_hit_i) begin
            state_d = ST_PEND;
            tag_d   = dis_tag_i;
        end else if (cmt_hit_i && (cmt_tag_i == tag_q) &&
                     ((state_q == ST_PEND) || (state_q == ST_INROB))) begin
            // A mismatching tag means a younger writer owns this entry.
            state_d = ST_FREE;
        end else if (cdb_valid_i && (state_q == ST_PEND) && (cdb_token_i == tag_q)) begin
            state_d = ST_INROB;
        end
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FREE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    assign state_o = state_q;
    assign tag_o   = tag_q;
endmodule

module reg_status_table #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rsaddr_dis,
    input  logic [4:0]       rtaddr_dis,
    output logic [TAG_W-1:0] rstag_rst,
    output logic             rsbusy_rst,
    output logic             rsinrob_rst,
    output logic [TAG_W-1:0] rttag_rst,
    output logic             rtbusy_rst,
    output logic             rtinrob_rst,
    input  logic             rdwen_dis,
    input  logic [4:0]       rdaddr_dis,
    input  logic [TAG_W-1:0] rdtag_dis,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_token,
    input  logic             cmt_valid,
    input  logic [4:0]       cmt_rdaddr,
    input  logic [TAG_W-1:0] cmt_tag,
    input  logic             flush
);
    localparam logic [1:0] ST_PEND  = 2'b01;
    localparam logic [1:0] ST_INROB = 2'b10;

    logic [31:0][1:0]       st;
    logic [31:0][TAG_W-1:0] tg;

    // r0 never renames.
    assign st[0] = '0;
    assign tg[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_ent
        reg_status_table_entry #(.TAG_W(TAG_W)) u_ent (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush),
            .dis_hit_i   (rdwen_dis && (rdaddr_dis == 5'(g))),
            .dis_tag_i   (rdtag_dis),
            .cmt_hit_i   (cmt_valid && (cmt_rdaddr == 5'(g))),
            .cmt_tag_i   (cmt_tag),
            .cdb_valid_i (cdb_valid),
            .cdb_token_i (cdb_token),
            .state_o     (st[g]),
            .tag_o       (tg[g])
        );
    end

    logic [1:0]       rs_st, rt_st;
    logic [TAG_W-1:0] rs_tg, rt_tg;
    logic             rs_pend, rt_pend;

    // Combinational read ports from pre-update state, with CDB bypass.
    always_comb begin
        rs_st   = st[rsaddr_dis];
        rs_tg   = tg[rsaddr_dis];
        rt_st   = st[rtaddr_dis];
        rt_tg   = tg[rtaddr_dis];
        rs_pend = (rs_st == ST_PEND);
        rt_pend = (rt_st == ST_PEND);

        // Illegal encoding 11 falls out as not busy here.
        rsbusy_rst  = rs_pend || (rs_st == ST_INROB);
        rtbusy_rst  = rt_pend || (rt_st == ST_INROB);
        rsinrob_rst = (rs_st == ST_INROB) || (rs_pend && cdb_valid && (cdb_token == rs_tg));
        rtinrob_rst = (rt_st == ST_INROB) || (rt_pend && cdb_valid && (cdb_token == rt_tg));
        rstag_rst   = rsbusy_rst ? rs_tg : '0;
        rttag_rst   = rtbusy_rst ? rt_tg : '0;
    end
endmodule

// File: tb/tb_reg_status_table.sv
// Bench for reg_status_table: directed scenarios then random traffic,
// all read ports compared against a per-register reference model.
module tb_reg_status_table;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rsaddr_dis = '0, rtaddr_dis = '0, rdaddr_dis = '0, cmt_rdaddr = '0;
    logic [5:0] rstag_rst, rttag_rst, rdtag_dis = '0, cdb_token = '0, cmt_tag = '0;
    logic       rsbusy_rst, rsinrob_rst, rtbusy_rst, rtinrob_rst;
    logic       rdwen_dis = 1'b0, cdb_valid = 1'b0, cmt_valid = 1'b0, flush = 1'b0;

    int tests = 0;
    int fails = 0;

    // Model: 0 = regfile up to date, 1 = awaiting result, 2 = result sits in ROB.
    int         m_st [32];
    logic [5:0] m_tg [32];

    reg_status_table #(.TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsaddr_dis(rsaddr_dis), .rtaddr_dis(rtaddr_dis),
        .rstag_rst(rstag_rst), .rsbusy_rst(rsbusy_rst), .rsinrob_rst(rsinrob_rst),
        .rttag_rst(rttag_rst), .rtbusy_rst(rtbusy_rst), .rtinrob_rst(rtinrob_rst),
        .rdwen_dis(rdwen_dis), .rdaddr_dis(rdaddr_dis), .rdtag_dis(rdtag_dis),
        .cdb_valid(cdb_valid), .cdb_token(cdb_token),
        .cmt_valid(cmt_valid), .cmt_rdaddr(cmt_rdaddr), .cmt_tag(cmt_tag),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_st[i] = 0;
            m_tg[i] = '0;
        end
    endtask

    // Compare all six read outputs with what the model says for the current addresses.
    task automatic check_reads(input string name);
        int a;
        bit busy, inrob;
        for (int p = 0; p < 2; p++) begin
            a     = (p == 0) ? int'(rsaddr_dis) : int'(rtaddr_dis);
            busy  = (m_st[a] != 0);
            inrob = (m_st[a] == 2) || (m_st[a] == 1 && cdb_valid && cdb_token == m_tg[a]);
            if (p == 0) begin
                chk({name, ".rsbusy"},  32'(rsbusy_rst),  32'(busy));
                chk({name, ".rsinrob"}, 32'(rsinrob_rst), 32'(inrob));
                chk({name, ".rstag"},   32'(rstag_rst),   busy ? 32'(m_tg[a]) : 32'd0);
            end else begin
                chk({name, ".rtbusy"},  32'(rtbusy_rst),  32'(busy));
                chk({name, ".rtinrob"}, 32'(rtinrob_rst), 32'(inrob));
                chk({name, ".rttag"},   32'(rttag_rst),   busy ? 32'(m_tg[a]) : 32'd0);
            end
        end
    endtask

    // Check reads, take one edge, apply the spec rules to the model, return idle inputs.
    task automatic tick(input string name);
        int         n_st [32];
        logic [5:0] n_tg [32];
        #2;
        check_reads(name);
        for (int i = 0; i < 32; i++) begin
            n_st[i] = m_st[i];
            n_tg[i] = m_tg[i];
            if (i == 0) continue;
            if (flush) begin
                n_st[i] = 0;
                n_tg[i] = '0;
            end else if (rdwen_dis && rdaddr_dis == 5'(i)) begin
                n_st[i] = 1;
                n_tg[i] = rdtag_dis;
            end else if (cmt_valid && cmt_rdaddr == 5'(i) && cmt_tag == m_tg[i] && m_st[i] != 0) begin
                n_st[i] = 0;
            end else if (cdb_valid && m_st[i] == 1 && cdb_token == m_tg[i]) begin
                n_st[i] = 2;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            m_st[i] = n_st[i];
            m_tg[i] = n_tg[i];
        end
        #1;
        rdwen_dis = 1'b0;
        cdb_valid = 1'b0;
        cmt_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic dis(input logic [4:0] a, input logic [5:0] t);
        rdwen_dis  = 1'b1;
        rdaddr_dis = a;
        rdtag_dis  = t;
    endtask

    task automatic cmt(input logic [4:0] a, input logic [5:0] t);
        cmt_valid  = 1'b1;
        cmt_rdaddr = a;
        cmt_tag    = t;
    endtask

    task automatic read(input logic [4:0] s, input logic [4:0] t);
        rsaddr_dis = s;
        rtaddr_dis = t;
    endtask

    initial begin
        int k;
        model_clear();

        // Reset state.
        read(5'd5, 5'd31);
        #2;
        chk("rst.rsbusy", 32'(rsbusy_rst), 0);
        chk("rst.rtbusy", 32'(rtbusy_rst), 0);
        chk("rst.rsinrob", 32'(rsinrob_rst), 0);
        chk("rst.rtinrob", 32'(rtinrob_rst), 0);
        chk("rst.rstag", 32'(rstag_rst), 0);
        chk("rst.rttag", 32'(rttag_rst), 0);
        #6 rst_n = 1'b1;   // t=8, away from edges
        @(posedge clk); #1;

        // Dispatch r3 tag 0x12; same-cycle read sees old state.
        read(5'd3, 5'd3);
        dis(5'd3, 6'h12);
        #1 chk("dis_same.busy", 32'(rsbusy_rst), 0);
        tick("dis");
        #1 chk("dis_next.busy", 32'(rsbusy_rst), 1);
        chk("dis_next.inrob", 32'(rsinrob_rst), 0);
        chk("dis_next.tag", 32'(rstag_rst), 32'h12);

        // CDB bypass, then INROB, then commit frees.
        cdb_valid = 1'b1; cdb_token = 6'h12;
        #1 chk("cdb_bypass.inrob", 32'(rsinrob_rst), 1);
        tick("cdb");
        #1 chk("inrob.inrob", 32'(rsinrob_rst), 1);
        chk("inrob.busy", 32'(rsbusy_rst), 1);
        cmt(5'd3, 6'h12);
        #1 chk("cmt_same.busy", 32'(rsbusy_rst), 1);
        chk("cmt_same.inrob", 32'(rsinrob_rst), 1);
        tick("cmt");
        #1 chk("cmt_next.busy", 32'(rsbusy_rst), 0);
        chk("cmt_next.tag", 32'(rstag_rst), 0);

        // Younger writer wins over stale commit.
        read(5'd7, 5'd7);
        dis(5'd7, 6'h05); tick("r7a");
        dis(5'd7, 6'h09); tick("r7b");
        cmt(5'd7, 6'h05); tick("r7c");
        #1 chk("stale_cmt.busy", 32'(rsbusy_rst), 1);
        chk("stale_cmt.tag", 32'(rstag_rst), 32'h09);
        dis(5'd7, 6'h0A); cmt(5'd7, 6'h09); tick("r7d");
        #1 chk("dis_over_cmt.tag", 32'(rstag_rst), 32'h0A);
        chk("dis_over_cmt.inrob", 32'(rsinrob_rst), 0);

        // r0 never allocates.
        read(5'd0, 5'd0);
        dis(5'd0, 6'h3F); tick("r0");
        #1 chk("r0.busy", 32'(rsbusy_rst), 0);
        chk("r0.tag", 32'(rttag_rst), 0);

        // Flush wins over a same-cycle dispatch.
        dis(5'd1, 6'h01); tick("f1");
        dis(5'd2, 6'h02); tick("f2");
        dis(5'd4, 6'h04); tick("f4");
        read(5'd1, 5'd4);
        flush = 1'b1; dis(5'd5, 6'h15); tick("flush");
        #1 chk("flush.r1busy", 32'(rsbusy_rst), 0);
        chk("flush.r4busy", 32'(rtbusy_rst), 0);
        read(5'd2, 5'd5);
        #1 chk("flush.r2busy", 32'(rsbusy_rst), 0);
        chk("flush.r5busy", 32'(rtbusy_rst), 0);

        // Asynchronous reset mid-cycle.
        dis(5'd9, 6'h19); tick("pre_rst");
        read(5'd9, 5'd9);
        #1 chk("pre_rst.busy", 32'(rsbusy_rst), 1);
        rst_n = 1'b0;
        #1 chk("async_rst.busy", 32'(rsbusy_rst), 0);
        chk("async_rst.tag", 32'(rttag_rst), 0);
        model_clear();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            read(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
            if ($urandom_range(0, 9) < 6)
                dis(5'($urandom_range(0, 9)), 6'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 9);
                cdb_valid = 1'b1;
                cdb_token = ($urandom_range(0, 3) != 0) ? m_tg[k] : 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 9);
                cmt(5'(k), ($urandom_range(0, 3) != 0) ? m_tg[k] : 6'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 40) == 0) flush = 1'b1;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_status_table.md
# reg_status_table

Register status table for the Tomasulo/ROB out-of-order core. It sits directly upstream of `regfile`, in the dispatch stage. It tracks, for each of the 32 architectural registers, whether the newest value is still in flight and which ROB tag will produce it. It supplies the rs/rt tags that `regfile` compares against the CDB token when assembling dispatch operands.

## Interface
- `TAG_W`, default 6: ROB tag width (64-entry ROB).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rsaddr_dis` in 5: rs source register of the instruction being dispatched.
- `rtaddr_dis` in 5: rt source register.
- `rstag_rst` out TAG_W: producing ROB tag for rs; 0 when rs is not busy.
- `rsbusy_rst` out 1: 1 means the architectural regfile value for rs is stale.
- `rsinrob_rst` out 1: 1 means the rs value is already produced and held in the ROB at `rstag_rst`.
- `rttag_rst`, `rtbusy_rst`, `rtinrob_rst` out TAG_W/1/1: same three outputs for rt.
- `rdwen_dis` in 1: dispatch allocates a destination this cycle.
- `rdaddr_dis` in 5: destination register.
- `rdtag_dis` in TAG_W: ROB tag assigned to the destination.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_token` in TAG_W: tag on the CDB.
- `cmt_valid` in 1: ROB commits an instruction with a register destination.
- `cmt_rdaddr` in 5: committed destination register.
- `cmt_tag` in TAG_W: ROB tag of the committing instruction.
- `flush` in 1: branch mispredict recovery.

## Operation
- Each entry holds a tag and a 2-bit state: FREE (00), PEND (01), INROB (10). Encoding 11 is illegal.
- Entry 0 is hardwired FREE with tag 0. Dispatch to r0 is ignored.
- Per-entry transitions are evaluated at each clock edge, highest priority first:
  1. `flush`: every entry goes to FREE with tag 0.
  2. Dispatch hit (`rdwen_dis` and `rdaddr_dis`==i, i≠0): entry goes to PEND and tag is set to `rdtag_dis`, from any state.
  3. Commit hit (`cmt_valid`, `cmt_rdaddr`==i, `cmt_tag`==entry tag, state≠FREE): entry goes to FREE. A tag mismatch means a younger writer owns the entry, so there is no change.
  4. CDB hit (`cdb_valid`, state==PEND, `cdb_token`==entry tag): entry goes to INROB.
  5. Otherwise the entry holds.
- Read ports are combinational from the current state:
  - busy = (state≠FREE).
  - inrob = (state==INROB) OR (state==PEND AND `cdb_valid` AND `cdb_token`==tag). The second term is the same-cycle CDB bypass.
  - tag = the entry tag when busy, otherwise 0.
- Same-cycle read and dispatch to the same register: the read returns the pre-update state. This gives correct renaming for `add r1,r1,r2`.
- Same-cycle commit and read of the same register: the read shows busy=1, INROB. The commit takes effect next cycle, and the ROB still supplies the value.
- Tags are compared at full TAG_W. There is no wrap-around handling beyond this; the ROB guarantees that a live tag is unique.
- A CDB broadcast to an entry that is in INROB or FREE state is ignored.
- An illegal state 11 is treated as FREE on read and recovers to FREE on the next edge.

## Timing
- Reset (`rst_n`=0, asynchronous): every entry is FREE with tag 0. All busy/inrob outputs are 0 and all tag outputs are 0 within the same cycle.
- Read latency is 0 cycles, purely combinational from the address and CDB inputs.
- Update latency is 1 cycle: a dispatch at edge N is visible on the read ports after edge N.
- Reset deasserting mid-operation: state is lost. The ROB and dispatch are reset together, so there is no handshake.
- `flush` is a 1-cycle pulse that acts at the next edge. `rdwen_dis` is ignored in a flush cycle.
- There is no back-pressure. The block accepts one dispatch, one CDB and one commit every cycle.

## Test plan
- Reset, then read rs=5, rt=31 → busy=0, inrob=0, tags=0.
- Dispatch r3 with tag 0x12, then read rs=3 the next cycle → busy=1, inrob=0, tag=0x12. Read the same cycle as the dispatch → busy=0.
- r3 PEND with tag 0x12; `cdb_valid`=1, `cdb_token`=0x12 → same-cycle read gives inrob=1 through the bypass; after the edge, state is INROB. Commit r3 with tag 0x12 → FREE next cycle.
- r7 dispatched with tag 0x05, then re-dispatched with tag 0x09. Commit r7 with tag 0x05 → r7 stays PEND with tag 0x09. Dispatch r7 with tag 0x0A and commit r7 with tag 0x09 in the same cycle → PEND with tag 0x0A.
- Dispatch r0 with tag 0x3F → r0 reads busy=0, tag=0.
- Dispatch r1, r2 and r4, then assert `flush` together with a dispatch of r5 → all entries FREE after the edge, r5 not allocated. Pull `rst_n` low mid-cycle → outputs go to 0 immediately.
